rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the single register-file write path between two writeback sources: req0 = ALU writeback, req1 = load/memory writeback.
- Drives the per-register write enables of the 16-bit registers in the register file as a registered one-hot vector, plus a common write-data bus.
- Round-robin arbitration with valid/ready handshake, R0 write suppression, halt control and a debug write counter.
- Sits between the execute/memory writeback logic and the register file.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 3, register index width (NREG = 2**ADDR_W = 8 registers)
ZERO_R0, 1, when 1, writes to register 0 are accepted but never drive a write enable

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
halt  input  1  when 1, no grants are issued; both readies are 0
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  destination register for req0
req0_data  input  DATA_W  write data for req0
req0_ready  output  1  req0 accepted this cycle (combinational)
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  destination register for req1
req1_data  input  DATA_W  write data for req1
req1_ready  output  1  req1 accepted this cycle (combinational)
rf_we  output  NREG  one-hot per-register write enable, registered
rf_wdata  output  DATA_W  write data to all registers, registered
wr_busy  output  1  1 when rf_we has any bit set this cycle
wr_count  output  16  number of committed register writes, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst=1 at a clock edge): rf_we=0, rf_wdata=0, wr_busy=0, wr_count=0, rr pointer=1 (req0 has priority first). Reset overrides any in-flight request; a request held across reset is re-arbitrated after rst falls.
- Handshake: transfer occurs when reqN_valid && reqN_ready in the same cycle. Requesters hold valid/addr/data stable until ready. readies are combinational from valids, halt and the rr pointer. Never both readies 1 in one cycle.
- Arbitration: halt=1 -> no grant. Only one valid -> that one granted. Both valid -> grant the requester other than the last granted (rr pointer); pointer updates only on an actual grant. Zero-latency accept; the arbiter never backpressures except for halt and losing arbitration.
- Latency: grant in cycle N -> rf_we[addr] = 1 and rf_wdata = data during cycle N+1, written into the register at edge N+2. Exactly one rf_we bit high for one cycle per grant. No grant -> rf_we = 0; rf_wdata holds its last value.
- R0: ZERO_R0=1 and granted addr=0 -> request is acknowledged (ready=1), rf_we stays 0 and wr_count does not increment. rf_wdata still updates. rr pointer still advances.
- wr_count increments by 1 on each cycle in which rf_we is nonzero; wraps modulo 2^16.
- Same-address conflict: both valid with the same addr -> serialized in grant order. The later grant wins as the final register value. No merging.
- halt asserted mid-stream: a grant already made in cycle N still produces its rf_we in N+1. No new grant occurs while halt=1.
- wr_busy = |rf_we, registered alongside rf_we.

Test Plan:
- Reset: drive rst=1 for 2 cycles with both valids high -> rf_we=8'h00, wr_count=0, both readies 0 during reset. First grant after rst falls goes to req0.
- Single source: req0 addr=3 data=16'hA5A5 for 1 cycle -> req0_ready=1 same cycle; next cycle rf_we=8'b0000_1000, rf_wdata=16'hA5A5; wr_count=1.
- Contention: both valid continuously (req0 addr=1 data=16'h1111, req1 addr=2 data=16'h2222) for 4 cycles -> grants alternate 0,1,0,1; rf_we sequence 02,04,02,04; wr_count=4.
- R0 suppression: req1 addr=0 data=16'hFFFF -> req1_ready=1, rf_we stays 8'h00 next cycle, wr_count unchanged.
- Halt: both valid with halt=1 for 3 cycles -> readies 0, rf_we 0. Deassert halt -> next grant follows the rr pointer unchanged from before halt.
- Wrap: preload 16'hFFFF writes (or force the counter to 16'hFFFF) then one write to addr 5 -> wr_count = 16'h0000, rf_we = 8'b0010_0000.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. Two writeback sources share one write path.
// Sources: req0 is the ALU writeback and req1 is the load writeback.
// Arbitration is round-robin with a zero-latency accept.
// Writes to R0 are dropped, and a halt input blocks all grants.
module rf_wr_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    halt,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  output logic [(2**ADDR_W)-1:0]  rf_we,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    wr_busy,
  output logic [15:0]             wr_count
);

  localparam int unsigned NREG  = 2**ADDR_W;
  localparam int unsigned CNT_W = 16;

  // 1 means req1 was granted last, so req0 wins the next tie.
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   we_next;

  // Grant decision: halt and reset block everything, ties go to the source not granted last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !halt) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Mux the winner's payload and build the one-hot enable, suppressing R0
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    we_next  = '0;
    if (grant1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
    if (grant0 || grant1) begin
      if (!((ZERO_R0 != 0) && (sel_addr == '0))) begin
        we_next[sel_addr] = 1'b1;
      end
    end
  end

  // Register the write-port outputs, the round-robin pointer and the commit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= '0;
      rf_wdata   <= '0;
      wr_busy    <= 1'b0;
      wr_count   <= '0;
      last_grant <= 1'b1;
    end else begin
      rf_we   <= we_next;
      wr_busy <= |we_next;
      if (grant0 || grant1) begin
        rf_wdata   <= sel_data;
        last_grant <= grant1;
      end
      // The count already includes the write that rf_we is presenting this cycle.
      if (|we_next) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Testbench for rf_wr_arbiter.
// Checks the design with directed scenarios that use literal expectations.
// Also checks a random stream against a transaction-level model on every cycle.
module tb_rf_wr_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [NREG-1:0]   rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              wr_busy;
  logic [15:0]       wr_count;

  int tests = 0;
  int fails = 0;

  rf_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .wr_busy    (wr_busy),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model, kept at the transaction level.
  // m_last records which source won last; a value of 1 means req0 has priority.
  int          m_last  = 1;
  bit          m_ok    = 1'b0;
  bit          g0      = 1'b0;
  bit          g1      = 1'b0;
  int unsigned m_count = 0;
  int unsigned m_we    = 0;
  int unsigned m_wdata = 0;

  // Returns which source should win: -1 means none, 0 means req0, 1 means req1.
  function automatic int winner(input bit r, input bit h, input bit v0, input bit v1, input int last);
    if (r || h) return -1;
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    int unsigned a;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      m_we = 0; m_wdata = 0; m_count = 0; m_last = 1; m_ok = 1'b1;
    end else begin
      w = winner(1'b0, halt, req0_valid, req1_valid, m_last);
      m_we = 0;
      if (w >= 0) begin
        g0 = (w == 0);
        g1 = (w == 1);
        a = (w == 0) ? int'(req0_addr) : int'(req1_addr);
        m_wdata = (w == 0) ? int'(req0_data) : int'(req1_data);
        m_last = w;
        if (a != 0) m_we = 1 << a;
      end
      if (m_we != 0) m_count = (m_count + 1) % 65536;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    int w;
    if (m_ok) begin
      w = winner(rst, halt, req0_valid, req1_valid, m_last);
      chk("req0_ready", 32'(req0_ready), 32'(w == 0));
      chk("req1_ready", 32'(req1_ready), 32'(w == 1));
      chk("rf_we",      32'(rf_we),      32'(m_we));
      chk("rf_wdata",   32'(rf_wdata),   32'(m_wdata));
      chk("wr_busy",    32'(wr_busy),    32'(m_we != 0));
      chk("wr_count",   32'(wr_count),   32'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;

    // Reset held with both sources requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_rdy0", 32'(req0_ready), 32'd0);
      chk("rst_rdy1", 32'(req1_ready), 32'd0);
      chk("rst_we",   32'(rf_we),      32'd0);
      chk("rst_cnt",  32'(wr_count),   32'd0);
      step();
    end
    rst = 1'b0;

    // Contention: grants alternate, starting with req0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_rdy0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("cont_rdy1", 32'(req1_ready), 32'((k % 2) == 1));
      if (k > 0) chk("cont_we", 32'(rf_we), ((k % 2) == 1) ? 32'h02 : 32'h04);
      chk("cont_cnt", 32'(wr_count), 32'(k));
      step();
    end

    // Single source
    req1_valid = 1'b0; req0_addr = 3'd3; req0_data = 16'hA5A5;
    @(negedge clk);
    chk("single_rdy0", 32'(req0_ready), 32'd1);
    chk("cont_last_we", 32'(rf_we), 32'h04);
    chk("cont_cnt4", 32'(wr_count), 32'd4);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_we",    32'(rf_we),    32'h08);
    chk("single_wdata", 32'(rf_wdata), 32'hA5A5);
    chk("single_busy",  32'(wr_busy),  32'd1);
    chk("single_cnt",   32'(wr_count), 32'd5);
    step();

    // R0 suppression
    req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 16'hFFFF;
    @(negedge clk);
    chk("r0_rdy1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("r0_we",    32'(rf_we),    32'h00);
    chk("r0_wdata", 32'(rf_wdata), 32'hFFFF);
    chk("r0_busy",  32'(wr_busy),  32'd0);
    chk("r0_cnt",   32'(wr_count), 32'd5);
    step();

    // Halt blocks grants; the pointer is preserved (req1 last, so req0 next)
    halt = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
    repeat (3) begin
      @(negedge clk);
      chk("halt_rdy0", 32'(req0_ready), 32'd0);
      chk("halt_rdy1", 32'(req1_ready), 32'd0);
      chk("halt_we",   32'(rf_we),      32'd0);
      step();
    end
    halt = 1'b0;
    @(negedge clk);
    chk("unhalt_rdy0", 32'(req0_ready), 32'd1);
    chk("unhalt_rdy1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("unhalt_we",  32'(rf_we),    32'h02);
    chk("unhalt_cnt", 32'(wr_count), 32'd6);
    step();

    // Random traffic; a request is held stable until the model shows it granted
    for (int n = 0; n < 3000; n++) begin
      if (!req0_valid || g0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        req0_data  = DATA_W'($urandom);
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        req1_data  = DATA_W'($urandom);
      end
      halt = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end

    // Counter wrap: 65535 writes, then one write to addr 5
    halt = 1'b0; req1_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0101;
    repeat (65535) step();
    req0_addr = 3'd5; req0_data = 16'h5555;
    @(negedge clk);
    chk("wrap_pre_cnt", 32'(wr_count), 32'hFFFF);
    chk("wrap_pre_we",  32'(rf_we),    32'h02);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wrap_cnt",   32'(wr_count), 32'h0000);
    chk("wrap_we",    32'(rf_we),    32'h20);
    chk("wrap_wdata", 32'(rf_wdata), 32'h5555);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
